// File: rtl/token_multiplier.sv
// Serial token expander: each input token on a becomes F output tokens on b (F from factor, 0->1, clamped to MAX_FACTOR).
// Latency: first copy appears on b one cycle after its token; copies follow contiguously while hold is low.
// Backpressure: hold suppresses emission while credit keeps accruing; credit saturates at MAX_PENDING and sets sticky overflow.
module token_multiplier #(
    parameter int MAX_FACTOR  = 4,
    parameter int MAX_PENDING = 200,
    localparam int FW = $clog2(MAX_FACTOR + 1),
    localparam int PW = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a,
    input  logic [FW-1:0] factor,
    input  logic          hold,
    output logic          b,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    // Internal sum must hold a full credit pool plus the largest single add.
    localparam int SW = $clog2(MAX_PENDING + MAX_FACTOR + 1);

    logic [FW-1:0] eff_factor;
    logic [SW-1:0] add;
    logic [SW-1:0] sum;
    logic [SW-1:0] nxt;
    logic          emit;
    logic          over;

    // Effective factor, credit update and overflow detection for this cycle.
    always_comb begin
        eff_factor = factor;
        if (factor == '0) begin
            eff_factor = FW'(1);
        end else if (factor > FW'(MAX_FACTOR)) begin
            eff_factor = FW'(MAX_FACTOR);
        end
        add  = a ? SW'(eff_factor) : '0;
        sum  = SW'(pending) + add;
        emit = !hold && (sum != '0);
        nxt  = sum - SW'(emit);
        over = (nxt > SW'(MAX_PENDING));
    end

    // Register output token, saturating credit count and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b        <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            b <= emit;
            if (over) begin
                pending  <= PW'(MAX_PENDING);
                overflow <= 1'b1;
            end else begin
                pending  <= PW'(nxt);
            end
        end
    end

endmodule
